arbiter4_rr: RTL
================

# arbiter4_rr

Four-way round-robin arbiter that shares one downstream resource between four requesters. Each cycle at most one requester holds the resource. The block drives a registered 2-bit grant index and a one-hot grant vector produced by 2-to-4 decode of that index. It sits between the requesting units and the shared datapath, and enforces a maximum hold time so that no requester can starve the others.

## Interface
Parameters:
- MAX_HOLD, default 8: maximum consecutive cycles one grant may last. Legal range 1..255.

Ports:
- clk  input  1  single system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  4  request lines; bit i is requester i and stays high while the requester wants or holds the resource.
- done  input  1  the current owner releases the resource; sampled only in GRANT.
- grant  output  4  one-hot grant. Equals 1<<gnt_idx while busy=1, otherwise 4'b0000.
- gnt_idx  output  2  index of the current, or most recent, grantee.
- busy  output  1  high while a grant is active.
- timeout  output  1  one-cycle pulse when a grant ends because MAX_HOLD was reached.

## Operation
- State machine with two states.
  - IDLE: busy=0, grant=0.
  - GRANT: busy=1, grant=decode(gnt_idx).
- Reset value of every output: grant=4'b0000, gnt_idx=2'b00, busy=0, timeout=0.
- Internal reset values: priority pointer ptr=2'b00, hold counter=0.
- IDLE → GRANT when req≠0.
  - Winner is the first set bit of req, scanning ptr, ptr+1, ptr+2, ptr+3, all mod 4.
  - gnt_idx is loaded with the winner.
  - Hold counter is loaded with 1.
- IDLE → IDLE when req=0. gnt_idx holds its last value.
- GRANT → IDLE when any release condition is true:
  - done=1,
  - req[gnt_idx]=0,
  - hold counter == MAX_HOLD.
- On release, ptr is set to gnt_idx+1 (mod 4), so the last owner gets lowest priority next time.
- GRANT → GRANT otherwise, and the hold counter increments.
- Counter width is the minimum needed to hold MAX_HOLD. The counter never exceeds MAX_HOLD and never wraps.
- timeout is set to 1 for exactly one cycle on the edge that leaves GRANT, but only when the hold limit was the sole release cause.
  - If done=1 or req[gnt_idx]=0 is true in the same cycle, timeout stays 0.
- done is ignored while in IDLE.
- req bits other than req[gnt_idx] have no effect during GRANT.
- Asynchronous reset asserted mid-grant: all outputs and internal state return to their reset values immediately, without waiting for a clock edge. After reset, ptr=0, so requester 0 has highest priority.

## Timing
- Request-to-grant latency is 1 cycle.
  - req sampled high at edge N gives grant, busy, and gnt_idx valid after edge N.
- Release-to-drop latency is 1 cycle.
  - done sampled at edge M gives grant=0 and busy=0 after edge M.
- There is always at least one IDLE bubble cycle between consecutive grants, even when other requests are pending.
- Grant duration:
  - If done is never asserted and req stays high, grant is high for exactly MAX_HOLD cycles.
  - If done is high in the first grant cycle, grant is high for 1 cycle.
- timeout is high in the first IDLE cycle after a limit-caused release, together with grant=0.
- All outputs come directly from registers. There are no combinational paths from req or done to any output.

## Test plan
- Reset: hold rst_n=0 with req=4'b1111.
  - Required: grant=0, busy=0, gnt_idx=0, timeout=0.
  - Release reset. Required: one cycle later grant=4'b0001.
- Single request: req=4'b0100, then done=1 in the 3rd grant cycle.
  - Required: gnt_idx=2 and grant=4'b0100 for exactly 3 cycles.
  - Then grant=0 and timeout=0.
- Round robin: req=4'b1111 held, done pulsed in every grant cycle.
  - Required grant sequence: 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000, 0001.
- Timeout with MAX_HOLD=8: req=4'b0011 held, done=0.
  - Required: grant=4'b0001 for 8 cycles.
  - Then one cycle of grant=0 with timeout=1.
  - Then grant=4'b0010.
- Release and timeout coincide: done=1 in the 8th grant cycle with MAX_HOLD=8.
  - Required: the grant ends and timeout stays 0.
- Requester drop and reset mid-grant:
  - While requester 3 is granted, set req[3]=0. Required: grant=0 on the next edge.
  - Grant requester 1, then pulse rst_n low between clock edges. Required: grant=0 immediately.
  - After reset, with req=4'b0011. Required: requester 0 is granted first.

Source files
------------

// File: rtl/arbiter4_rr_if.sv
// Handshake bundle between four requesters and the round-robin arbiter.
// The master side drives req/done; the slave (arbiter) side drives the grant outputs.
interface arbiter4_rr_if;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic [1:0] gnt_idx;
  logic       busy;
  logic       timeout;

  modport master (output req, done, input grant, gnt_idx, busy, timeout);
  modport slave  (input req, done, output grant, gnt_idx, busy, timeout);
endinterface

// File: rtl/arbiter4_rr.sv
// Four-way round-robin arbiter with a bounded hold time; every output is a register.
// The last owner drops to lowest priority on release, and there is always one idle bubble between grants.
module arbiter4_rr #(
  parameter int MAX_HOLD = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  arbiter4_rr_if.slave bus
);
  localparam int N  = 4;
  localparam int CW = $clog2(MAX_HOLD + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state;
  logic [1:0]      ptr;
  logic [CW-1:0]   hold;
  logic [1:0]      win, idx;
  logic [N-1:0]    win_oh;
  logic            at_lim, rel;

  // Scan from the far end back toward ptr so the closest set bit wins.
  always_comb begin
    win = ptr;
    idx = ptr;
    for (int k = N-1; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (bus.req[idx]) win = idx;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_dec
    assign win_oh[i] = (win == 2'(i));
  end

  assign at_lim = (hold == CW'(MAX_HOLD));
  assign rel    = bus.done | ~bus.req[bus.gnt_idx] | at_lim;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      hold        <= '0;
      bus.grant   <= '0;
      bus.gnt_idx <= '0;
      bus.busy    <= 1'b0;
      bus.timeout <= 1'b0;
    end else begin
      bus.timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (|bus.req) begin
            state       <= GRANT;
            bus.gnt_idx <= win;
            bus.grant   <= win_oh;
            bus.busy    <= 1'b1;
            hold        <= CW'(1);
          end
        end
        GRANT: begin
          if (rel) begin
            state       <= IDLE;
            bus.grant   <= '0;
            bus.busy    <= 1'b0;
            ptr         <= bus.gnt_idx + 2'd1;
            // Only flag a timeout when the limit alone ended the grant.
            bus.timeout <= at_lim & ~bus.done & bus.req[bus.gnt_idx];
          end else begin
            hold <= hold + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
